// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common
//   Shared definitions for the boot-time program loader.
//   - loader_state_t : frame-parser FSM states
//   - LOADER_MAGIC   : first byte of every load frame
// -----------------------------------------------------------------------------
package common;

  typedef enum logic [2:0] {
    WAIT_MAGIC = 3'd0,
    LEN        = 3'd1,
    DATA       = 3'd2,
    CSUM       = 3'd3,
    DONE       = 3'd4,
    ERROR      = 3'd5
  } loader_state_t;

  localparam logic [7:0] LOADER_MAGIC = 8'hA5;

endpackage : common

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Boot-time program loader. Parses a framed byte stream
//     A5 | len[7:0] len[15:8] len[23:16] len[31:24] | payload[len] | sum8
//   writes each payload byte to the CPU program memory at BASE_ADDR + index,
//   and holds the CPU in reset until a checksum-verified image is in place.
//
// Ports
//   clk, reset_n              : clock, asynchronous active-low reset
//   rx_valid, rx_data         : upstream byte stream (held while rx_ready=0)
//   rx_ready                  : loader accepts a byte this cycle
//   start                     : begin a new session (honoured in DONE/ERROR)
//   write_address/_data/_enable : byte-wide program-memory write port
//   cpu_reset_n               : CPU reset, released only after a good image
//   busy, done, error         : session status
// -----------------------------------------------------------------------------
module prog_loader
  import common::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic [31:0] write_address,
  output logic [7:0]  write_data,
  output logic        write_enable,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  loader_state_t state_q, state_d;
  logic [31:0]   index_q, index_d;
  logic [31:0]   len_q, len_d;
  logic [1:0]    len_cnt_q, len_cnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          accept;
  logic [31:0]   len_asm;

  // Handshake and status decode straight from the state register.
  assign rx_ready = (state_q != DONE) && (state_q != ERROR);
  assign busy     = rx_ready;
  assign accept   = rx_valid && rx_ready;

  // Length arrives LSB first: shift each byte in at the top so that after
  // four bytes the first one has landed in bits [7:0].
  assign len_asm  = {rx_data, len_q[31:8]};

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; that is what keeps this block free of latches.
    state_d   = state_q;
    index_d   = index_q;
    len_d     = len_q;
    len_cnt_d = len_cnt_q;
    sum_d     = sum_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;

    unique case (state_q)
      WAIT_MAGIC: begin
        // Anything other than the magic byte is dropped to resync the stream.
        if (accept && rx_data == LOADER_MAGIC) begin
          state_d   = LEN;
          len_cnt_d = 2'd0;
        end
      end

      LEN: begin
        if (accept) begin
          len_d     = len_asm;
          len_cnt_d = len_cnt_q + 2'd1;
          if (len_cnt_q == 2'd3) begin
            if (len_asm > 32'(MAX_BYTES)) state_d = ERROR;
            else if (len_asm == 32'd0)    state_d = CSUM;
            else                          state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          we_d    = 1'b1;
          waddr_d = BASE_ADDR + index_q;
          wdata_d = rx_data;
          sum_d   = sum_q + rx_data;
          index_d = index_q + 32'd1;
          if (index_d == len_q) state_d = CSUM;
        end
      end

      CSUM: begin
        if (accept) state_d = (rx_data == sum_q) ? DONE : ERROR;
      end

      DONE, ERROR: begin
        if (start) begin
          state_d   = WAIT_MAGIC;
          index_d   = 32'd0;
          len_d     = 32'd0;
          len_cnt_d = 2'd0;
          sum_d     = 8'd0;
        end
      end

      default: state_d = WAIT_MAGIC;
    endcase

    // Status flags are registered copies of the next state, so they change
    // in the same cycle the state does. The CPU is only released in DONE;
    // the final payload write is already issued by then.
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERROR);
    cpu_rst_n_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_MAGIC;
      index_q     <= '0;
      len_q       <= '0;
      len_cnt_q   <= '0;
      sum_q       <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, independent of statement order.
      state_q     <= state_d;
      index_q     <= index_d;
      len_q       <= len_d;
      len_cnt_q   <= len_cnt_d;
      sum_q       <= sum_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign write_enable  = we_q;
  assign cpu_reset_n   = cpu_rst_n_q;
  assign done          = done_q;
  assign error         = err_q;

endmodule : prog_loader
